// File: rtl/axi_master_arbiter_w.sv
// Write-path round-robin arbiter for a 4-master AXI write mux.
// Holds one registered one-hot grant from AW request through the B handshake.
module axi_master_arbiter_w #(
  parameter int NUM_M     = 4,
  parameter int RESET_PTR = 0
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       m0_AWVALID,
  input  logic       m1_AWVALID,
  input  logic       m2_AWVALID,
  input  logic       m3_AWVALID,
  input  logic       s_AWVALID,
  input  logic       m_AWREADY,
  input  logic       s_WVALID,
  input  logic       s_WLAST,
  input  logic       m_WREADY,
  input  logic       m_BVALID,
  input  logic       s_BREADY,
  output logic       m0_wgrnt,
  output logic       m1_wgrnt,
  output logic       m2_wgrnt,
  output logic       m3_wgrnt,
  output logic       w_busy,
  output logic [1:0] w_last_grant
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  // Seeding the pointer one below RESET_PTR makes RESET_PTR the first index scanned.
  localparam logic [1:0] RST_LAST = 2'((RESET_PTR + 3) % 4);

  state_t           state_q, state_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [NUM_M-1:0] req;
  logic [1:0]       last_q, last_d;
  logic [1:0]       pick, idx;
  logic             pick_vld;
  logic             aw_hs, w_last_hs, b_hs;

  assign req       = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
  assign aw_hs     = s_AWVALID & m_AWREADY;
  assign w_last_hs = s_WVALID & s_WLAST & m_WREADY;
  assign b_hs      = m_BVALID & s_BREADY;

  // Scan from furthest to nearest offset so the nearest requester after last_q wins.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = NUM_M; i >= 1; i--) begin
      idx = last_q + 2'(i);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      grant_q   <= '0;
      last_q    <= RST_LAST;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    grant_d   = grant_q;
    last_d    = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
          state_d       = XFER;
        end
      end
      // AW and WLAST may arrive in either order or together; B is ignored here.
      XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        if (aw_done_d && w_done_d) state_d = RESP;
      end
      RESP: begin
        if (b_hs) begin
          grant_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_wgrnt     = grant_q[0];
    m1_wgrnt     = grant_q[1];
    m2_wgrnt     = grant_q[2];
    m3_wgrnt     = grant_q[3];
    w_busy       = |grant_q;
    w_last_grant = last_q;
  end

endmodule

// File: tb/tb_axi_master_arbiter_w.sv
// Bench for axi_master_arbiter_w: directed scenarios plus randomized traffic,
// checked per cycle against a transaction-level reference model through queues.
module tb_axi_master_arbiter_w;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic       m0_AWVALID = 1'b0, m1_AWVALID = 1'b0, m2_AWVALID = 1'b0, m3_AWVALID = 1'b0;
  logic       s_AWVALID = 1'b0, m_AWREADY = 1'b0;
  logic       s_WVALID = 1'b0, s_WLAST = 1'b0, m_WREADY = 1'b0;
  logic       m_BVALID = 1'b0, s_BREADY = 1'b0;
  logic       m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt;
  logic       w_busy;
  logic [1:0] w_last_grant;

  // hs bit order: {s_AWVALID, m_AWREADY, s_WVALID, s_WLAST, m_WREADY, m_BVALID, s_BREADY}
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] AW = 7'b1100000;
  localparam logic [6:0] WB = 7'b0010100;
  localparam logic [6:0] WL = 7'b0011100;
  localparam logic [6:0] B  = 7'b0000011;

  int tests = 0;
  int fails = 0;

  logic [6:0] exp_q[$];
  int         grant_q[$];
  int         obs_q[$];

  axi_master_arbiter_w #(.NUM_M(4), .RESET_PTR(0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWVALID(m0_AWVALID), .m1_AWVALID(m1_AWVALID),
    .m2_AWVALID(m2_AWVALID), .m3_AWVALID(m3_AWVALID),
    .s_AWVALID(s_AWVALID), .m_AWREADY(m_AWREADY),
    .s_WVALID(s_WVALID), .s_WLAST(s_WLAST), .m_WREADY(m_WREADY),
    .m_BVALID(m_BVALID), .s_BREADY(s_BREADY),
    .m0_wgrnt(m0_wgrnt), .m1_wgrnt(m1_wgrnt), .m2_wgrnt(m2_wgrnt), .m3_wgrnt(m3_wgrnt),
    .w_busy(w_busy), .w_last_grant(w_last_grant)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction owner, the set of completion events seen,
  // and the rotating priority list starting after the last winner.
  int mo_owner = -1;
  int mo_last  = 3;
  bit mo_aw = 0, mo_w = 0, mo_resp = 0;

  always @(posedge ACLK) begin
    logic [3:0] r;
    logic [3:0] g;
    r = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
    if (!ARESETn) begin
      mo_owner = -1; mo_last = 3; mo_aw = 0; mo_w = 0; mo_resp = 0;
    end else if (mo_owner < 0) begin
      for (int k = 1; k <= 4; k++)
        if (mo_owner < 0 && r[(mo_last + k) % 4]) mo_owner = (mo_last + k) % 4;
      if (mo_owner >= 0) begin
        mo_last = mo_owner;
        grant_q.push_back(mo_owner);
      end
    end else if (!mo_resp) begin
      if (s_AWVALID && m_AWREADY) mo_aw = 1;
      if (s_WVALID && s_WLAST && m_WREADY) mo_w = 1;
      if (mo_aw && mo_w) mo_resp = 1;
    end else if (m_BVALID && s_BREADY) begin
      mo_owner = -1; mo_aw = 0; mo_w = 0; mo_resp = 0;
    end
    g = (mo_owner >= 0) ? (4'b0001 << mo_owner) : 4'b0000;
    exp_q.push_back({g, mo_owner >= 0, 2'(mo_last)});
  end

  // Monitor: per-cycle output compare, invariants, and grant-order scoreboard.
  logic prev_busy = 1'b0;
  always @(negedge ACLK) begin
    logic [6:0] act, e;
    logic [3:0] g;
    int gi, want;
    g   = {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt};
    act = {g, w_busy, w_last_grant};
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL cycle: no expected entry, got %0h", act);
    end else begin
      e = exp_q.pop_front();
      check("cycle", 32'(act), 32'(e));
    end
    check("onehot_busy", {31'd0, ($countones(g) <= 1) && (w_busy == |g)}, 32'd1);
    if (w_busy && !prev_busy) begin
      gi = -1;
      for (int k = 0; k < 4; k++) if (g[k]) gi = k;
      obs_q.push_back(gi);
      if (grant_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL grant_order: got master %0d, expected none", gi);
      end else begin
        want = grant_q.pop_front();
        check("grant_order", 32'(gi), 32'(want));
      end
    end
    prev_busy = w_busy;
  end

  task automatic cyc(input logic [3:0] req, input logic [6:0] hs);
    {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID} = req;
    {s_AWVALID, m_AWREADY, s_WVALID, s_WLAST, m_WREADY, m_BVALID, s_BREADY} = hs;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic pulse_reset();
    {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID} = 4'b0;
    {s_AWVALID, m_AWREADY, s_WVALID, s_WLAST, m_WREADY, m_BVALID, s_BREADY} = NO;
    #2 ARESETn = 1'b0;
    #1 check("rst_async", {25'd0, m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt, w_busy, w_last_grant},
             {25'd0, 4'b0000, 1'b0, 2'd3});
    @(posedge ACLK);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
  endtask

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};

    // Power-on reset
    @(posedge ACLK);
    @(negedge ACLK);
    check("reset_state", {25'd0, m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt, w_busy, w_last_grant},
          {25'd0, 4'b0000, 1'b0, 2'd3});
    #2 ARESETn = 1'b1;

    // Single request from m2 with a 4-beat burst
    cyc(4'b0100, NO);
    check("single_grant", {28'd0, m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt}, 32'b0100);
    cyc(4'b0000, AW);
    cyc(4'b0000, WB); cyc(4'b0000, WB); cyc(4'b0000, WB);
    cyc(4'b0000, WL);
    check("single_resp_hold", {31'd0, m2_wgrnt}, 32'd1);
    cyc(4'b0000, B);
    check("single_release", {31'd0, w_busy}, 32'd0);
    check("single_last", {30'd0, w_last_grant}, 32'd2);

    // All four requesting continuously from reset
    pulse_reset();
    obs_q.delete();
    for (int t = 0; t < 5; t++) begin
      cyc(4'b1111, NO);
      cyc(4'b1111, AW | WL);
      cyc(4'b1111, B);
      check("rr_gap", {31'd0, w_busy}, 32'd0);
    end
    check("rr_count", 32'(obs_q.size()), 32'd5);
    for (int t = 0; t < 5 && t < obs_q.size(); t++) check("rr_order", 32'(obs_q[t]), 32'(order[t]));

    // W burst completes before the AW handshake
    cyc(4'b0010, NO);
    cyc(4'b0000, WB);
    cyc(4'b0000, WL);
    cyc(4'b0000, NO);
    check("wfirst_hold", {31'd0, m1_wgrnt}, 32'd1);
    cyc(4'b0000, NO);
    cyc(4'b0000, AW);
    cyc(4'b0000, NO);
    check("wfirst_resp", {31'd0, m1_wgrnt}, 32'd1);
    cyc(4'b0000, B);
    check("wfirst_release", {31'd0, w_busy}, 32'd0);

    // BVALID asserted early, during XFER
    cyc(4'b1000, NO);
    cyc(4'b0000, B);
    cyc(4'b0000, AW | B);
    cyc(4'b0000, WB | B);
    check("early_b_hold", {31'd0, m3_wgrnt}, 32'd1);
    cyc(4'b0000, WL | B);
    check("early_b_resp", {31'd0, m3_wgrnt}, 32'd1);
    cyc(4'b0000, B);
    check("early_b_release", {31'd0, w_busy}, 32'd0);

    // AW, WLAST and B all in one cycle on a single-beat burst
    cyc(4'b0001, NO);
    cyc(4'b0000, AW | WL | B);
    check("simul_resp", {31'd0, m0_wgrnt}, 32'd1);
    cyc(4'b0000, B);
    check("simul_release", {31'd0, w_busy}, 32'd0);

    // Reset in the middle of an m3 transaction
    cyc(4'b1000, NO);
    cyc(4'b0000, AW);
    pulse_reset();
    cyc(4'b1001, NO);
    check("post_rst_m0", {28'd0, m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt}, 32'b0001);
    cyc(4'b0000, AW | WL);
    cyc(4'b0000, B);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else cyc(4'($urandom), 7'($urandom));
    end

    cyc(4'b0000, NO);
    cyc(4'b0000, NO);
    check("grant_q_drain", 32'(grant_q.size()), 32'd0);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_master_arbiter_w.md
Name: axi_master_arbiter_w

Overview:
- Write-path arbiter for the 4-master AXI write multiplexer; generates the one-hot m0..m3_wgrnt select lines that steer AW/W/B between masters and the shared slave port.
- Round-robin among masters presenting AWVALID.
- Holds a grant for one complete write transaction: AW handshake, W burst through WLAST, B handshake.
- Sits beside the write mux in the interconnect; observes only the shared-side handshake signals.

Parameters:
- NUM_M, 4, number of masters; fixed at 4, other values unsupported.
- RESET_PTR, 0, master index holding highest priority after reset (0..3).

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESETn  in  1  asynchronous active-low reset.
- m0_AWVALID..m3_AWVALID  in  1 each  per-master write requests.
- s_AWVALID  in  1  muxed AWVALID toward slave.
- m_AWREADY  in  1  slave AWREADY.
- s_WVALID  in  1  muxed WVALID.
- s_WLAST  in  1  muxed WLAST.
- m_WREADY  in  1  slave WREADY.
- m_BVALID  in  1  slave BVALID.
- s_BREADY  in  1  muxed BREADY.
- m0_wgrnt..m3_wgrnt  out  1 each  registered one-hot grants, at most one high.
- w_busy  out  1  high while any grant is held.
- w_last_grant  out  2  index of most recently granted master.

Behaviour:
- Reset, asynchronous, active-low: all wgrnt=0, w_busy=0, state=IDLE, aw_done=0, w_done=0, w_last_grant=RESET_PTR-1 mod 4, so RESET_PTR is searched first.
- Handshake events, all sampled at the ACLK edge:
  - aw_hs = s_AWVALID & m_AWREADY
  - w_last_hs = s_WVALID & s_WLAST & m_WREADY
  - b_hs = m_BVALID & s_BREADY
- IDLE:
  - If any mN_AWVALID, select the first requester scanning from w_last_grant+1 upward, modulo 4.
  - Register its wgrnt=1, w_busy=1, update w_last_grant; go to XFER.
  - Latency: request at edge k, grant visible after edge k+1.
  - With no request, stay in IDLE with all grants 0.
- XFER:
  - aw_hs sets aw_done; w_last_hs sets w_done.
  - Both may occur in the same cycle, and in either order, since W may lead AW.
  - W beats before WLAST only pass through.
  - When aw_done and w_done are both set, counting events of the current cycle, go to RESP.
- RESP:
  - Wait for b_hs. On b_hs, clear all wgrnt, w_busy, aw_done and w_done; go to IDLE.
  - b_hs is honoured only in RESP. In XFER it is ignored and not stored, because the slave may not respond before WLAST.
- Fairness: a master whose transaction just finished has lowest priority in the next arbitration.
- Idle gap: exactly one all-zero grant cycle between back-to-back transactions, including re-grant to the same master.
- Request withdrawal: requests are sampled only in IDLE. A master that drops AWVALID after grant keeps the grant (AXI forbids withdrawal).
- Grants never change mid-transaction; there is no preemption.
- Reset mid-operation: grants drop immediately and asynchronously. Any in-flight transaction is abandoned with no recovery.
- Invariant: wgrnt is always one-hot or all-zero. w_busy equals the OR of the grants.

Test Plan:
- Single request: m2_AWVALID=1, AW handshake, 4-beat W with WLAST on beat 4, B handshake → m2_wgrnt high from cycle after request through B handshake cycle, then 0 for 1 cycle; w_last_grant=2.
- All four request continuously from reset, RESET_PTR=0 → grant order 0,1,2,3,0, each with one idle cycle between.
- W-before-AW: m1 granted, WLAST handshake at cycle 3, AW handshake at cycle 6, BVALID at cycle 8 → RESP entered after cycle 6; grant released after b_hs at cycle 8.
- Early BVALID: m_BVALID=1 in XFER before WLAST → grant held; b_hs ignored until RESP; a later b_hs releases the grant.
- Simultaneous AW, WLAST and B-ready in one cycle for a single-beat burst → enter RESP next cycle; B in the following cycle releases the grant.
- ARESETn pulsed low mid-XFER with m3 granted → all wgrnt=0 immediately. After release with m0 and m3 requesting, m0 is granted first.
